// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Command-buffering stage in front of the 16-bit combinational ALU. Commands
// arrive over a valid/ready handshake, wait in a DEPTH-entry FIFO, and the head
// entry is driven onto the ALU inputs. The ALU's outputs are captured into a
// result register that is offered downstream over a second valid/ready
// handshake. When nothing stalls, one operation completes per cycle with a
// fixed latency of two cycles.
//
// Optional feature (macro ALU_ISSUE_ACC_EN):
//   Adds a WIDTH-bit accumulator loaded with alu_result on every capture. A
//   command with use_acc=1 takes the accumulator as operand A. Capture and
//   pop happen on the same edge, so a dependent command right behind its
//   producer sees the new value without a bubble.
//   With the macro undefined, cmd_use_acc is ignored and never stored.
//
// Parameters:
//   WIDTH  operand/result width (must match the ALU)
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready = FIFO not full)
//   cmd_a, cmd_b             operands
//   cmd_select, cmd_mode     ALU select code and mode (1 logic, 0 arithmetic)
//   cmd_carry, cmd_use_acc   carry input; take accumulator as operand A
//   alu_a, alu_b, alu_select, alu_mode, alu_carry_in
//                            head entry driven to the ALU (zero when empty)
//   alu_result, alu_carry_out, alu_compare
//                            ALU outputs, captured on each fire
//   res_valid / res_ready    result handshake
//   res_data, res_carry, res_compare
//                            registered result
//   fifo_level               entries in the FIFO (output register excluded)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [3:0]               cmd_select,
  input  logic                     cmd_mode,
  input  logic                     cmd_carry,
  input  logic                     cmd_use_acc,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_select,
  output logic                     alu_mode,
  output logic                     alu_carry_in,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry_out,
  input  logic                     alu_compare,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_carry,
  output logic                     res_compare,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Command storage, one array per field.
  logic [WIDTH-1:0] a_mem      [DEPTH];
  logic [WIDTH-1:0] b_mem      [DEPTH];
  logic [3:0]       select_mem [DEPTH];
  logic             mode_mem   [DEPTH];
  logic             carry_mem  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic fifo_empty;
  logic push;
  logic fire;

  assign fifo_empty = (level == '0);
  // Ready comes from the registered level only, so a pop in the same cycle
  // never opens a slot for a push: no path from res_ready to cmd_ready.
  assign cmd_ready  = (level != FULL_LEVEL);
  assign push       = cmd_valid && cmd_ready;
  // Capture whenever there is a head entry and the output register is free
  // or being emptied this cycle.
  assign fire       = !fifo_empty && (!res_valid || res_ready);
  assign fifo_level = level;

`ifdef ALU_ISSUE_ACC_EN
  logic             use_acc_mem [DEPTH];
  logic [WIDTH-1:0] acc;
`else
  // cmd_use_acc has no function in this build; tie it off.
  logic unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
`endif

  // NOTE: storage arrays carry no reset; an entry is only read after it has
  // been written, and reset already empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]      <= cmd_a;
      b_mem[wr_ptr]      <= cmd_b;
      select_mem[wr_ptr] <= cmd_select;
      mode_mem[wr_ptr]   <= cmd_mode;
      carry_mem[wr_ptr]  <= cmd_carry;
`ifdef ALU_ISSUE_ACC_EN
      use_acc_mem[wr_ptr] <= cmd_use_acc;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fire) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Output register: load on fire, clear on a drain without refill,
  // otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_carry   <= 1'b0;
      res_compare <= 1'b0;
    end else if (fire) begin
      res_valid   <= 1'b1;
      res_data    <= alu_result;
      res_carry   <= alu_carry_out;
      res_compare <= alu_compare;
    end else if (res_valid && res_ready) begin
      res_valid   <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_ACC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (fire) begin
      acc <= alu_result;
    end
  end
`endif

  // NOTE: every output gets its default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_select   = '0;
    alu_mode     = 1'b0;
    alu_carry_in = 1'b0;
    if (!fifo_empty) begin
      alu_a        = a_mem[rd_ptr];
      alu_b        = b_mem[rd_ptr];
      alu_select   = select_mem[rd_ptr];
      alu_mode     = mode_mem[rd_ptr];
      alu_carry_in = carry_mem[rd_ptr];
`ifdef ALU_ISSUE_ACC_EN
      if (use_acc_mem[rd_ptr]) alu_a = acc;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Self-checking bench for alu_issue_stage. A small behavioural ALU closes the
// loop on the alu_* ports. The reference model is a queue of commands plus a
// held-result slot; each cycle it predicts cmd_ready, the operands on the ALU
// port, the registered result and fifo_level. Directed steps cover reset,
// the add/xor examples, full-capacity stall and drain, mid-operation reset and
// the accumulator sequence, followed by randomized traffic.
// Build with +define+ALU_ISSUE_ACC_EN to exercise the accumulator build.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [3:0]       cmd_select;
  logic             cmd_mode, cmd_carry, cmd_use_acc;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_select;
  logic             alu_mode, alu_carry_in;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry_out, alu_compare;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry, res_compare;
  logic [LW-1:0]    fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_select   (cmd_select),
    .cmd_mode     (cmd_mode),
    .cmd_carry    (cmd_carry),
    .cmd_use_acc  (cmd_use_acc),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_mode     (alu_mode),
    .alu_carry_in (alu_carry_in),
    .alu_result   (alu_result),
    .alu_carry_out(alu_carry_out),
    .alu_compare  (alu_compare),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_compare  (res_compare),
    .fifo_level   (fifo_level)
  );

  // Behavioural ALU. Carries are active-low (carry_in=1 means no carry in,
  // carry_out=1 means no carry out). Returns {compare, carry_out, result}.
  function automatic logic [WIDTH+1:0] alu_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [3:0] sel,
                                              input logic mode,
                                              input logic cin);
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   s;
    logic             co;
    co = 1'b1;
    if (mode) begin
      case (sel)
        4'd6:    r = a ^ b;
        4'd11:   r = a & b;
        4'd14:   r = a | b;
        4'd0:    r = ~a;
        default: r = ~(a ^ b);
      endcase
    end else begin
      case (sel)
        4'd9:    s = {1'b0, a} + {1'b0, b} + {16'd0, !cin};
        4'd6:    s = {1'b0, a} + {1'b0, ~b} + {16'd0, !cin};
        default: s = {1'b0, a} + {16'd0, !cin};
      endcase
      r  = s[WIDTH-1:0];
      co = !s[WIDTH];
    end
    return {(a == b), co, r};
  endfunction

  assign {alu_compare, alu_carry_out, alu_result} =
    alu_fn(alu_a, alu_b, alu_select, alu_mode, alu_carry_in);

  // ---------------------------------------------------------------- model --
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             mode;
    logic             carry;
    logic             use_acc;
  } cmd_t;

  cmd_t             q[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_carry;
  logic             m_cmp;
  logic [WIDTH-1:0] m_acc;

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_carry = 1'b0;
    m_cmp   = 1'b0;
    m_acc   = '0;
  endtask

  // Operand A as the ALU should see it for a command at the head.
  function automatic logic [WIDTH-1:0] eff_a(input cmd_t c);
`ifdef ALU_ISSUE_ACC_EN
    return c.use_acc ? m_acc : c.a;
`else
    return c.a;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Entered at posedge+1; drives inputs, checks the
  // combinational outputs, advances the model, then checks registered
  // outputs at the next posedge+1. 'accepted' reports an observed handshake.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [3:0] sel,
                       input logic mode, input logic carry,
                       input logic use_acc, input logic rr,
                       output logic accepted);
    cmd_t       c, h;
    logic       push, fire;
    logic [WIDTH+1:0] r;
    cmd_valid = v; cmd_a = a; cmd_b = b; cmd_select = sel;
    cmd_mode = mode; cmd_carry = carry; cmd_use_acc = use_acc;
    res_ready = rr;
    #1;
    check("cmd_ready", cmd_ready, q.size() != DEPTH);
    if (q.size() == 0) begin
      check("alu_a_idle", alu_a, 0);
      check("alu_b_idle", alu_b, 0);
      check("alu_ctl_idle", {alu_select, alu_mode, alu_carry_in}, 0);
    end else begin
      check("alu_a", alu_a, eff_a(q[0]));
      check("alu_b", alu_b, q[0].b);
      check("alu_ctl", {alu_select, alu_mode, alu_carry_in},
            {q[0].sel, q[0].mode, q[0].carry});
    end
    accepted = v && cmd_ready;
    c    = '{a: a, b: b, sel: sel, mode: mode, carry: carry, use_acc: use_acc};
    push = v && (q.size() != DEPTH);
    fire = (q.size() != 0) && (!m_valid || rr);
    if (fire) begin
      h = q.pop_front();
      r = alu_fn(eff_a(h), h.b, h.sel, h.mode, h.carry);
      m_data  = r[WIDTH-1:0];
      m_carry = r[WIDTH];
      m_cmp   = r[WIDTH+1];
      m_valid = 1'b1;
      m_acc   = r[WIDTH-1:0];
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    if (push) q.push_back(c);
    @(posedge clk);
    #1;
    check("res_valid", res_valid, m_valid);
    if (m_valid) begin
      check("res_data", res_data, m_data);
      check("res_flags", {res_carry, res_compare}, {m_carry, m_cmp});
    end
    check("fifo_level", fifo_level, q.size());
  endtask

  task automatic idle(input logic rr);
    logic acc_unused;
    cycle(1'b0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, rr, acc_unused);
  endtask

  // ------------------------------------------------------------- stimulus --
  initial begin
    logic       acc_flag;
    int         n_acc;
    logic [3:0] sel_tab [5];
    sel_tab[0] = 4'd9; sel_tab[1] = 4'd6; sel_tab[2] = 4'd11;
    sel_tab[3] = 4'd14; sel_tab[4] = 4'd0;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_select = '0;
    cmd_mode = 1'b0; cmd_carry = 1'b0; cmd_use_acc = 1'b0; res_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_flags", {res_carry, res_compare}, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_alu", {alu_a, alu_b, alu_select, alu_mode, alu_carry_in}, 0);
    rst = 1'b0;
    idle(1'b1);
    idle(1'b1);

    // Add 3+5 with no carry in: latency two, valid for one cycle.
    cycle(1'b1, 16'd3, 16'd5, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, acc_flag);
    idle(1'b1);
    check("add_data", res_data, 8);
    check("add_carry", res_carry, 1);
    check("add_compare", res_compare, 0);
    check("add_valid", res_valid, 1);
    idle(1'b1);
    check("add_valid_one_cycle", res_valid, 0);

    // XOR of equal operands.
    cycle(1'b1, 16'h00FF, 16'h00FF, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, acc_flag);
    idle(1'b1);
    check("xor_data", res_data, 0);
    check("xor_compare", res_compare, 1);
    idle(1'b1);

    // Capacity with downstream stalled: DEPTH in the FIFO plus one held.
    n_acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      cycle(1'b1, WIDTH'(16'h100 + i), WIDTH'(i), 4'd9, 1'b0, 1'b1, 1'b0,
            1'b0, acc_flag);
      if (acc_flag) n_acc++;
    end
    check("full_accepted", n_acc, DEPTH + 1);
    check("full_level", fifo_level, DEPTH);
    check("full_ready", cmd_ready, 0);
    // Drain in order on consecutive cycles; ready returns after one pop.
    idle(1'b1);
    check("drain_ready_back", cmd_ready, 1);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    check("drain_empty", res_valid, 0);

    // Reset with three queued and one held.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, WIDTH'(16'h20 + i), 16'd1, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0,
            acc_flag);
    check("pre_rst_level", fifo_level, 3);
    check("pre_rst_valid", res_valid, 1);
    cmd_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", cmd_ready, 1);
    model_reset();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Accumulator dependency, back-to-back.
    cycle(1'b1, 16'd1, 16'd2, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, acc_flag);
    cycle(1'b1, 16'd99, 16'd10, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, acc_flag);
    check("acc_first", res_data, 3);
    idle(1'b1);
    check("acc_second_valid", res_valid, 1);
`ifdef ALU_ISSUE_ACC_EN
    check("acc_second", res_data, 13);
`else
    check("acc_second", res_data, 109);
`endif
    idle(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
            sel_tab[$urandom_range(0, 4)], 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 2) != 0), acc_flag);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    check("final_level", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-buffering stage directly upstream of the 16-bit ALU. Accepts ALU operations over a valid/ready handshake, queues them in a small FIFO, and drives the head entry onto the ALU's combinational operand/opcode inputs. It captures the ALU's result, carry and compare outputs into an output register presented downstream with its own valid/ready handshake. Sustains one operation per cycle with fixed two-cycle latency when unstalled.

## Interface
- WIDTH, 16: operand/result width; must match the ALU.
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  stage accepts command this cycle.
- cmd_a, cmd_b  in  WIDTH  operands.
- cmd_select  in  4  ALU select code.
- cmd_mode  in  1  ALU mode (1 logic, 0 arithmetic).
- cmd_carry  in  1  carry input for the op.
- cmd_use_acc  in  1  replace operand A with accumulator (only with ALU_ISSUE_ACC_EN).
- alu_a, alu_b  out  WIDTH  to ALU in_a/in_b.
- alu_select  out  4, alu_mode  out  1, alu_carry_in  out  1  to ALU.
- alu_result  in  WIDTH, alu_carry_out  in  1, alu_compare  in  1  from ALU.
- res_valid  out  1  result held.
- res_ready  in  1  downstream consumes.
- res_data  out  WIDTH, res_carry  out  1, res_compare  out  1  registered result.
- fifo_level  out  $clog2(DEPTH)+1  entries in FIFO (excludes output register).

## Operation
- Push: cmd_valid && cmd_ready writes {a,b,select,mode,carry,use_acc} at write pointer. cmd_ready = (fifo_level != DEPTH). No push when full, even if a pop occurs that cycle.
- ALU drive: when FIFO non-empty, alu_* = head entry fields; when empty, alu_* = 0.
- Capture: fire = (FIFO non-empty) && (!res_valid || res_ready). On fire: res_data <= alu_result, res_carry <= alu_carry_out, res_compare <= alu_compare, res_valid <= 1, head popped.
- Drain: res_valid && res_ready && !fire → res_valid <= 0.
- Simultaneous push and pop: both take effect; fifo_level unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level tracked in a separate counter, range 0..DEPTH.
- Output register holds value stable while res_valid && !res_ready.
- Total capacity with downstream stalled: DEPTH+1 commands.
- Reset (any time, including mid-operation) discards all queued and held operations.

## Timing
- Reset values: cmd_ready=1, res_valid=0, res_data=0, res_carry=0, res_compare=0, fifo_level=0, alu_*=0, pointers=0, accumulator=0.
- Command accepted at edge N is at the FIFO head during cycle N+1. It is captured at edge N+1 and is visible on res_* from cycle N+2 (latency 2).
- Back-to-back commands with res_ready=1 produce results on consecutive cycles.
- cmd_ready depends only on registered level (no combinational path from res_ready).
- res_valid is registered (no combinational path from cmd_valid).

## Configuration
- ALU_ISSUE_ACC_EN defined:
  - Adds a WIDTH-bit accumulator, loaded with alu_result on every fire.
  - When the head's use_acc=1, alu_a = accumulator instead of the stored a.
  - Dependent back-to-back ops see the just-captured result with no bubble, because capture and pop share the edge.
- ALU_ISSUE_ACC_EN undefined:
  - No accumulator.
  - cmd_use_acc is ignored and not stored.
  - alu_a is always the stored a.

## Test plan
- Reset then idle → cmd_ready=1, res_valid=0, fifo_level=0, all alu_*=0.
- Push mode=0, select=9, a=3, b=5, carry=1 with res_ready=1 → two cycles later res_data=8, res_carry=1, res_compare=0, res_valid high for one cycle.
- Push mode=1, select=6, a=16'h00FF, b=16'h00FF → res_data=0, res_compare=1.
- DEPTH=4, res_ready=0, cmd_valid held → exactly 5 accepted, then cmd_ready=0, fifo_level=4. Raise res_ready → 5 results drain in order on consecutive cycles and cmd_ready returns next cycle.
- Assert rst with 3 queued and 1 held → res_valid=0 and fifo_level=0 immediately. No stale results after release.
- With ALU_ISSUE_ACC_EN: push (9,mode0,a=1,b=2), then (9,mode0,use_acc=1,a=99,b=10) back-to-back → results 3 then 13. Without the macro, the same sequence gives 3 then 109.
